// File: rtl/keyboard_cursor_ctrl_if.sv
// Key handshake between the cursor controller (master) and the key consumer (slave).
interface keyboard_cursor_ctrl_if #(
    parameter int unsigned IDX_W = 5
) ();
    logic [IDX_W-1:0] key_index;
    logic             key_valid;
    logic             key_ack;

    modport master (output key_index, output key_valid, input key_ack);
    modport slave  (input key_index, input key_valid, output key_ack);
endinterface

// File: rtl/keyboard_cursor_ctrl.sv
// On-screen keyboard navigator: cursor over a ROWS x COLS grid (short last row),
// edge-detected buttons with hold-to-repeat, select key with valid/ack handshake,
// and the QI/QRUN/QDONE one-hot session FSM.
module keyboard_cursor_ctrl #(
    parameter int unsigned ROWS          = 3,
    parameter int unsigned COLS          = 10,
    parameter int unsigned LAST_ROW_COLS = 8,
    parameter int unsigned WRAP          = 0,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned IDX_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic                           Clk,
    input  logic                           reset,
    input  logic                           Start,
    input  logic                           Ack,
    input  logic                           done,
    input  logic                           U,
    input  logic                           D,
    input  logic                           L,
    input  logic                           R,
    input  logic                           C,
    output logic [RW-1:0]                  cursor_row,
    output logic [CW-1:0]                  cursor_col,
    output logic                           q_I,
    output logic                           q_Run,
    output logic                           q_Done,
    keyboard_cursor_ctrl_if.master         key_if
);

    typedef enum logic [2:0] {
        StI    = 3'b100,
        StRun  = 3'b010,
        StDone = 3'b001
    } state_e;

    localparam logic [RW-1:0] LastRow    = RW'(ROWS - 1);
    localparam logic [CW-1:0] ColMax     = CW'(COLS - 1);
    localparam logic [CW-1:0] LastColMax = CW'(LAST_ROW_COLS - 1);

    state_e           state_q, state_d;
    logic [RW-1:0]    row_q, row_d, mv_row;
    logic [CW-1:0]    col_q, col_d, row_end;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [4:0]       btn, prev_q, ev;
    logic [3:0]       dir;
    logic [31:0]      cnt_q, cnt_d, limit;
    logic             rep_q, rep_d, rep_fire, held_same;

    // Button vector ordered by priority: U, D, L, R, C.
    assign btn       = {U, D, L, R, C};
    assign dir       = btn[4:1];
    assign held_same = $onehot(dir) && ((dir & prev_q[4:1]) == dir);
    assign limit     = rep_q ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY);
    assign row_end   = (row_q == LastRow) ? LastColMax : ColMax;
    assign ev        = (btn & ~prev_q) | {(rep_fire ? dir : 4'b0000), 1'b0};

    // Hold-to-repeat: first extra event after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
    always_comb begin
        cnt_d    = '0;
        rep_d    = 1'b0;
        rep_fire = 1'b0;
        if (state_q == StRun && held_same) begin
            if (cnt_q + 32'd1 >= limit) begin
                rep_fire = 1'b1;
                rep_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
                rep_d = rep_q;
            end
        end
    end

    // Session FSM, cursor movement and key select/handshake next-state.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        mv_row  = row_q;
        if (valid_q && key_if.key_ack) begin
            valid_d = 1'b0;
        end
        case (state_q)
            StI: begin
                row_d = '0;
                col_d = '0;
                if (Start) state_d = StRun;
            end
            StRun: begin
                if (done) begin
                    state_d = StDone;
                end else if (ev[4] || ev[3]) begin
                    if (ev[4]) begin
                        if (row_q == '0) mv_row = (WRAP != 0) ? LastRow : row_q;
                        else             mv_row = row_q - 1'b1;
                    end else begin
                        if (row_q == LastRow) mv_row = (WRAP != 0) ? '0 : row_q;
                        else                  mv_row = row_q + 1'b1;
                    end
                    row_d = mv_row;
                    // Entering the short last row pulls the column inside it.
                    if (mv_row == LastRow && col_q > LastColMax) col_d = LastColMax;
                end else if (ev[2]) begin
                    if (col_q == '0) col_d = (WRAP != 0) ? row_end : col_q;
                    else             col_d = col_q - 1'b1;
                end else if (ev[1]) begin
                    if (col_q == row_end) col_d = (WRAP != 0) ? '0 : col_q;
                    else                  col_d = col_q + 1'b1;
                end else if (ev[0] && !valid_q) begin
                    idx_d   = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
                    valid_d = 1'b1;
                end
            end
            StDone: begin
                if (Ack) begin
                    state_d = StI;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            default: begin
                state_d = StI;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= StI;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            prev_q  <= '0;
            cnt_q   <= '0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            prev_q  <= btn;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
        end
    end

    assign cursor_row        = row_q;
    assign cursor_col        = col_q;
    assign q_I               = state_q[2];
    assign q_Run             = state_q[1];
    assign q_Done            = state_q[0];
    assign key_if.key_index  = idx_q;
    assign key_if.key_valid  = valid_q;

endmodule

// File: tb/tb_keyboard_cursor_ctrl.sv
// Directed bench: clamp-mode instance A walks the main scenarios, wrap-mode instance B
// covers edge wrapping. Repeat timing shortened to DELAY=4, PERIOD=2.
module tb_keyboard_cursor_ctrl;

    localparam logic [4:0] BU = 5'b10000;
    localparam logic [4:0] BD = 5'b01000;
    localparam logic [4:0] BL = 5'b00100;
    localparam logic [4:0] BR = 5'b00010;
    localparam logic [4:0] BC = 5'b00001;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A (WRAP=0)
    logic       a_rst, a_start, a_ack, a_done, a_kack;
    logic [4:0] a_btn;
    logic [1:0] a_row;
    logic [3:0] a_col;
    logic       a_qi, a_qr, a_qd;
    keyboard_cursor_ctrl_if #(.IDX_W(5)) a_if ();
    assign a_if.key_ack = a_kack;

    keyboard_cursor_ctrl #(
        .ROWS(3), .COLS(10), .LAST_ROW_COLS(8), .WRAP(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) u_dut_a (
        .Clk(Clk), .reset(a_rst), .Start(a_start), .Ack(a_ack), .done(a_done),
        .U(a_btn[4]), .D(a_btn[3]), .L(a_btn[2]), .R(a_btn[1]), .C(a_btn[0]),
        .cursor_row(a_row), .cursor_col(a_col),
        .q_I(a_qi), .q_Run(a_qr), .q_Done(a_qd), .key_if(a_if.master)
    );

    // Instance B (WRAP=1)
    logic       b_rst, b_start, b_ack, b_done, b_kack;
    logic [4:0] b_btn;
    logic [1:0] b_row;
    logic [3:0] b_col;
    logic       b_qi, b_qr, b_qd;
    keyboard_cursor_ctrl_if #(.IDX_W(5)) b_if ();
    assign b_if.key_ack = b_kack;

    keyboard_cursor_ctrl #(
        .ROWS(3), .COLS(10), .LAST_ROW_COLS(8), .WRAP(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) u_dut_b (
        .Clk(Clk), .reset(b_rst), .Start(b_start), .Ack(b_ack), .done(b_done),
        .U(b_btn[4]), .D(b_btn[3]), .L(b_btn[2]), .R(b_btn[1]), .C(b_btn[0]),
        .cursor_row(b_row), .cursor_col(b_col),
        .q_I(b_qi), .q_Run(b_qr), .q_Done(b_qd), .key_if(b_if.master)
    );

    // Column after each cycle of a continuous R hold from column 0.
    int exp_col [22] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 9, 9, 9, 9};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_a_cur(input string tag, input int r, input int c);
        chk({tag, "_row"}, 32'(a_row), 32'(r));
        chk({tag, "_col"}, 32'(a_col), 32'(c));
    endtask

    task automatic chk_b_cur(input string tag, input int r, input int c);
        chk({tag, "_row"}, 32'(b_row), 32'(r));
        chk({tag, "_col"}, 32'(b_col), 32'(c));
    endtask

    task automatic chk_a_st(input string tag, input logic [2:0] exp);
        chk(tag, 32'({a_qi, a_qr, a_qd}), 32'(exp));
    endtask

    task automatic pulse_a(input logic [4:0] m);
        a_btn = m;
        tick();
        a_btn = '0;
        tick();
    endtask

    task automatic pulse_b(input logic [4:0] m);
        b_btn = m;
        tick();
        b_btn = '0;
        tick();
    endtask

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_ack = 1'b0; a_done = 1'b0; a_kack = 1'b0; a_btn = '0;
        b_rst = 1'b1; b_start = 1'b0; b_ack = 1'b0; b_done = 1'b0; b_kack = 1'b0; b_btn = '0;
        tick();

        // Reset state
        chk_a_st("rst_state", 3'b100);
        chk_a_cur("rst_cur", 0, 0);
        chk("rst_valid", 32'(a_if.key_valid), 32'd0);
        chk("rst_index", 32'(a_if.key_index), 32'd0);

        // Scenario 1: start, three R taps, select, acknowledge
        a_rst = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk_a_st("s1_run", 3'b010);
        repeat (3) pulse_a(BR);
        chk_a_cur("s1_cur", 0, 3);
        pulse_a(BC);
        chk("s1_valid", 32'(a_if.key_valid), 32'd1);
        chk("s1_index", 32'(a_if.key_index), 32'd3);
        a_kack = 1'b1;
        tick();
        a_kack = 1'b0;
        chk("s1_acked", 32'(a_if.key_valid), 32'd0);

        // Back to (0,0) through a session cycle
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk_a_st("cyc_idle", 3'b100);
        chk_a_cur("cyc_cur", 0, 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;

        // Scenario 2: continuous R hold with auto-repeat and right-edge clamp
        a_btn = BR;
        for (int k = 0; k < 22; k++) begin
            tick();
            chk($sformatf("s2_hold_k%0d", k), 32'(a_col), 32'(exp_col[k]));
        end
        a_btn = '0;
        tick();
        chk_a_cur("s2_after", 0, 9);

        // Scenario 3: short last row clamp and right edge on last row
        pulse_a(BD);
        chk_a_cur("s3_row1", 1, 9);
        pulse_a(BD);
        chk_a_cur("s3_row2_clamp", 2, 7);
        pulse_a(BR);
        chk_a_cur("s3_right_edge", 2, 7);
        pulse_a(BD);
        chk_a_cur("s3_bottom_edge", 2, 7);
        pulse_a(BU);
        chk_a_cur("s3_leave_last", 1, 7);

        // Scenario 4: simultaneous U+L, double select without ack
        pulse_a(BL);
        pulse_a(BL);
        chk_a_cur("s4_pos", 1, 5);
        a_btn = BU | BL;
        tick();
        chk_a_cur("s4_ul", 0, 5);
        a_btn = '0;
        tick();
        chk_a_cur("s4_ul_hold", 0, 5);
        pulse_a(BU);
        chk_a_cur("s4_top_edge", 0, 5);
        pulse_a(BC);
        chk("s4_valid", 32'(a_if.key_valid), 32'd1);
        chk("s4_index", 32'(a_if.key_index), 32'd5);
        pulse_a(BR);
        chk_a_cur("s4_r", 0, 6);
        pulse_a(BC);
        chk("s4_index2", 32'(a_if.key_index), 32'd5);
        chk("s4_valid2", 32'(a_if.key_valid), 32'd1);

        // Scenario 5: done with R edge, Ack, pending key survives
        a_done = 1'b1;
        a_btn = BR;
        tick();
        a_done = 1'b0;
        a_btn = '0;
        chk_a_st("s5_done", 3'b001);
        chk_a_cur("s5_nomove", 0, 6);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk_a_st("s5_idle", 3'b100);
        chk_a_cur("s5_cur", 0, 0);
        tick();
        chk("s5_pending", 32'(a_if.key_valid), 32'd1);
        chk("s5_pend_idx", 32'(a_if.key_index), 32'd5);
        a_kack = 1'b1;
        tick();
        chk("s5_acked", 32'(a_if.key_valid), 32'd0);
        tick();
        a_kack = 1'b0;
        chk("s5_ack_noop", 32'(a_if.key_valid), 32'd0);

        // Scenario 6: reset mid-run with pending key and R held
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        pulse_a(BC);
        chk("s6_valid", 32'(a_if.key_valid), 32'd1);
        chk("s6_index", 32'(a_if.key_index), 32'd0);
        a_btn = BR;
        tick();
        chk_a_cur("s6_move", 0, 1);
        tick();
        tick();
        a_rst = 1'b1;
        tick();
        chk_a_st("s6_rst_state", 3'b100);
        chk_a_cur("s6_rst_cur", 0, 0);
        chk("s6_rst_valid", 32'(a_if.key_valid), 32'd0);
        a_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("s6_norep_col_k%0d", k), 32'(a_col), 32'd0);
        end
        a_btn = '0;
        tick();

        // Wrap-mode instance
        b_rst = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("w_run", 32'({b_qi, b_qr, b_qd}), 32'(3'b010));
        pulse_b(BD);
        pulse_b(BD);
        chk_b_cur("w_down2", 2, 0);
        pulse_b(BL);
        chk_b_cur("w_left_wrap", 2, 7);
        pulse_b(BR);
        chk_b_cur("w_right_wrap", 2, 0);
        pulse_b(BU);
        pulse_b(BU);
        repeat (4) pulse_b(BR);
        chk_b_cur("w_pos", 0, 4);
        pulse_b(BU);
        chk_b_cur("w_up_wrap", 2, 4);
        pulse_b(BD);
        chk_b_cur("w_down_wrap", 0, 4);
        pulse_b(BL);
        pulse_b(BL);
        pulse_b(BL);
        pulse_b(BL);
        pulse_b(BL);
        chk_b_cur("w_left_row0_wrap", 0, 9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
